counter_mod_lv163x: RTL

//  Parametrised successor to the 4-bit 74x163-style counter model. Synchronous
//  up/down counter of any width with programmable modulus, parallel load,

---
 rtl/counter_mod_lv163x.sv | 88 ++++++++
 1 files changed

// File: rtl/counter_mod_lv163x.sv
// Parametrised synchronous up/down counter with programmable modulus, parallel load,
// synchronous clear and cascadable terminal count (74x163-style, any width).
module counter_mod_lv163x #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 2 ** WIDTH,
    parameter int INIT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             pe_n,
    input  logic             sr_n,
    input  logic             cep,
    input  logic             cet,
    input  logic             ud,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("counter_mod_lv163x: WIDTH must be >= 1");
        end
        if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $error("counter_mod_lv163x: MODULUS must lie in 2..2**WIDTH");
        end
        if ((INIT < 0) || (INIT >= MODULUS)) begin : g_bad_init
            $error("counter_mod_lv163x: INIT must be below MODULUS");
        end
    endgenerate

    // Widened compare keeps the test meaningful when MODULUS spans the full width.
    function automatic logic out_of_range(input logic [WIDTH-1:0] cur);
        return {1'b0, cur} > {1'b0, TERM_VAL};
    endfunction

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur);
        return ((cur == TERM_VAL) || out_of_range(cur)) ? ZERO_VAL : cur + ONE_VAL;
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur);
        return ((cur == ZERO_VAL) || out_of_range(cur)) ? TERM_VAL : cur - ONE_VAL;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] step_s;
    logic             count_en_s;
    logic             tc_s;

    // Next-state selection: clear beats load beats count beats hold.
    // Ternaries on ud/cet/cep let an unknown enable or direction show up on q.
    always_comb begin
        count_en_s = cet & cep;
        step_s     = ud ? step_up(q_r) : step_down(q_r);
        next_s     = q_r;
        if (!sr_n) begin
            next_s = ZERO_VAL;
        end else if (!pe_n) begin
            next_s = d;
        end else begin
            next_s = count_en_s ? step_s : q_r;
        end
    end

    // Counter state register; rst forces INIT immediately and holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= INIT_VAL;
        end else begin
            q_r <= next_s;
        end
    end

    // Terminal count: exact match only, so out-of-range loads never raise it.
    always_comb begin
        tc_s = cet & (ud ? (q_r == TERM_VAL) : (q_r == ZERO_VAL));
    end

    assign q  = q_r;
    assign tc = tc_s;

endmodule
